ldpc_frame_loader: RTL

Serial-to-word input stage of the bit-flipping LDPC decoder. It accepts hard-decision channel bits one per cycle over a valid/ready handshake and packs them LSB-first into 8-bit words. It writes the words into a 16 x 8 frame memory and, once a full 128-bit frame is stored, hands the frame to the decoder core through a valid/ack handshake. The decoder reads the stored words through a combinational read port.

---
 rtl/ldpc_bf_pkg.sv | 16 +
 rtl/ldpc_bit_packer.sv | 58 +++++
 rtl/ldpc_frame_loader.sv | 90 +++++++++
 3 files changed

// File: rtl/ldpc_bf_pkg.sv
// rtl/ldpc_bf_pkg.sv - shared constants and loader state type for the bit-flipping LDPC decoder
package ldpc_bf_pkg;

    localparam int WORD_W     = 8;
    localparam int DEPTH      = 16;
    localparam int AW         = $clog2(DEPTH);
    localparam int FRAME_BITS = WORD_W * DEPTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int BIT_W      = $clog2(WORD_W);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } loader_state_t;

endpackage

// File: rtl/ldpc_bit_packer.sv
// rtl/ldpc_bit_packer.sv - serial bit counter and LSB-first word packer with frame/length strobes
module ldpc_bit_packer
    import ldpc_bf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_accept,
    input  logic              i_bit,
    input  logic              i_last,
    output logic [WORD_W-1:0] o_word,
    output logic [AW-1:0]     o_wr_addr,
    output logic              o_word_we,
    output logic              o_frame_done,
    output logic              o_len_err
);

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WORD_W-2:0] r_shreg;

    logic [BIT_W-1:0]  w_pos;
    logic              w_word_end;
    logic              w_frame_end;
    logic              w_short;

    // Position decode: the top bit of a word goes straight to memory, never into the shift register
    always_comb begin
        w_pos       = r_bit_cnt[BIT_W-1:0];
        w_word_end  = &w_pos;
        w_frame_end = &r_bit_cnt;
        w_short     = i_accept && i_last && !w_frame_end;
        o_word      = {i_bit, r_shreg};
        o_wr_addr   = r_bit_cnt[CNT_W-1:BIT_W];
        o_word_we   = i_accept && w_word_end && !w_short;
        o_frame_done = i_accept && w_frame_end;
        o_len_err   = i_accept && (w_frame_end ? !i_last : i_last);
    end

    // Count accepted bits and collect the lower bits of the current word; a short frame restarts from bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (i_accept) begin
            if (w_short) begin
                r_bit_cnt <= '0;
                r_shreg   <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_word_end) begin
                    r_shreg <= '0;
                end else begin
                    r_shreg[w_pos] <= i_bit;
                end
            end
        end
    end

endmodule

// File: rtl/ldpc_frame_loader.sv
// rtl/ldpc_frame_loader.sv - serial-to-word frame loader with 16x8 frame memory and decoder handshake
module ldpc_frame_loader
    import ldpc_bf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_bit,
    input  logic              s_last,
    output logic              frame_valid,
    input  logic              frame_ack,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              err_len
);

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic              r_err_len;

    logic              w_accept;
    logic [WORD_W-1:0] w_word;
    logic [AW-1:0]     w_wr_addr;
    logic              w_word_we;
    logic              w_frame_done;
    logic              w_len_err;

    assign w_accept = s_valid && s_ready;

    ldpc_bit_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_accept     (w_accept),
        .i_bit        (s_bit),
        .i_last       (s_last),
        .o_word       (w_word),
        .o_wr_addr    (w_wr_addr),
        .o_word_we    (w_word_we),
        .o_frame_done (w_frame_done),
        .o_len_err    (w_len_err)
    );

    // Loader state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Commit to HOLD on the last bit of a frame, return to FILL on decoder ack
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: if (w_frame_done) w_state_next = ST_HOLD;
            ST_HOLD: if (frame_ack)    w_state_next = ST_FILL;
            default: w_state_next = ST_FILL;
        endcase
    end

    // Handshake outputs decode from state alone so s_ready never depends on s_valid
    always_comb begin
        s_ready     = (r_state == ST_FILL);
        frame_valid = (r_state == ST_HOLD);
    end

    // Frame memory: whole-word writes only, contents survive reset
    always_ff @(posedge clk) begin
        if (w_word_we) begin
            r_mem[w_wr_addr] <= w_word;
        end
    end

    assign rd_data = r_mem[rd_addr];

    // One-cycle length-violation pulse following the offending beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_len <= 1'b0;
        end else begin
            r_err_len <= w_len_err;
        end
    end

    assign err_len = r_err_len;

endmodule
